// File: rtl/tensor_op_dispatcher.sv
// Config-word dispatcher: FIFO-buffers 118-bit config words, decodes the
// operator field and issues the payload to the selected operator engine,
// tracking per-engine busy status via single-cycle done pulses.
module tensor_op_dispatcher #(
    parameter int unsigned NUM_ENG    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [117:0]                  cfg_in_tdata,
    input  logic                          cfg_in_tvalid,
    output logic                          cfg_in_tready,
    output logic [112:0]                  eng_tdata,
    output logic [NUM_ENG-1:0]            eng_tvalid,
    input  logic [NUM_ENG-1:0]            eng_tready,
    input  logic [NUM_ENG-1:0]            eng_done,
    output logic [NUM_ENG-1:0]            eng_busy,
    output logic                          err_valid,
    output logic [4:0]                    err_opcode,
    output logic [7:0]                    err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CFG_W = 118;
    localparam int unsigned OPC_W = 5;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned CNT_W = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [CFG_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [0:0]             state;
    logic [0:0]             state_n;

    logic [CFG_W-1:0]       head;
    logic [OPC_W-1:0]       opc;
    logic                   opc_bad;
    logic [NUM_ENG-1:0]     sel_onehot;
    logic                   push;
    logic                   pop;
    logic [LW-1:0]          level_n;
    logic [CFG_W-OPC_W-1:0] tdata_n;
    logic [NUM_ENG-1:0]     tvalid_n;
    logic [NUM_ENG-1:0]     busy_n;
    logic                   err_valid_n;
    logic [OPC_W-1:0]       err_opcode_n;
    logic [CNT_W-1:0]       err_count_n;

    assign head       = fifo_mem[rd_ptr];
    assign opc        = head[OPC_W-1:0];
    assign opc_bad    = 32'(opc) >= NUM_ENG;
    assign sel_onehot = NUM_ENG'(1) << opc;

    // Next-state, FIFO control and next-output decode
    always_comb begin
        state_n      = state;
        pop          = 1'b0;
        tdata_n      = eng_tdata;
        tvalid_n     = eng_tvalid;
        busy_n       = eng_busy & ~eng_done;
        err_valid_n  = 1'b0;
        err_opcode_n = err_opcode;
        err_count_n  = err_count;
        push         = cfg_in_tvalid && cfg_in_tready;

        case (state)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    if (opc_bad) begin
                        pop          = 1'b1;
                        err_valid_n  = 1'b1;
                        err_opcode_n = opc;
                        if (err_count != {CNT_W{1'b1}}) begin
                            err_count_n = err_count + CNT_W'(1);
                        end
                    end else if ((sel_onehot & eng_busy) == '0) begin
                        tdata_n  = head[CFG_W-1:OPC_W];
                        tvalid_n = sel_onehot;
                        state_n  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // eng_tvalid is one-hot, so this only sees the selected engine's ready
                if ((eng_tvalid & eng_tready) != '0) begin
                    pop      = 1'b1;
                    busy_n   = busy_n | eng_tvalid;
                    tvalid_n = '0;
                    state_n  = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        level_n = fifo_level;
        if (push && !pop) begin
            level_n = fifo_level + LW'(1);
        end else if (!push && pop) begin
            level_n = fifo_level - LW'(1);
        end
    end

    // State, pointer and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            cfg_in_tready <= 1'b0;
            eng_tdata     <= '0;
            eng_tvalid    <= '0;
            eng_busy      <= '0;
            err_valid     <= 1'b0;
            err_opcode    <= '0;
            err_count     <= '0;
        end else begin
            state         <= state_n;
            fifo_level    <= level_n;
            cfg_in_tready <= (level_n != LW'(FIFO_DEPTH));
            eng_tdata     <= tdata_n;
            eng_tvalid    <= tvalid_n;
            eng_busy      <= busy_n;
            err_valid     <= err_valid_n;
            err_opcode    <= err_opcode_n;
            err_count     <= err_count_n;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // FIFO storage, no reset needed since level gates every read
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cfg_in_tdata;
        end
    end

endmodule

// File: doc/tensor_op_dispatcher.md
Name: tensor_op_dispatcher

Overview:
- Sits between the config ingress stream and the tensor operator engines (bitcast, reshape, transpose, ...).
- Buffers incoming 118-bit config words in a small FIFO and decodes the operator field (bits 4:0).
- Issues each word, stripped of the operator field, to the selected engine over a valid/ready handshake.
- Tracks per-engine busy status through done pulses, so no engine receives a new config before it finishes the previous one.

Parameters:
NUM_ENG, 4, number of operator engines; opcode k selects engine k
FIFO_DEPTH, 4, config FIFO entries (power of two, >=2)

Ports:
clock  in  1  clock
reset_n  in  1  reset, synchronous, active-low
cfg_in_tdata  in  118  config word: [4:0] operator, [9:5] sub-op, [49:10] src dims, [89:50] dst dims, [100:90] src addr, [111:101] dst addr, [114:112] in size, [117:115] out size
cfg_in_tvalid  in  1  config word valid
cfg_in_tready  out  1  FIFO not full
eng_tdata  out  113  shared engine payload = head word bits [117:5] (out bit i = in bit i+5)
eng_tvalid  out  NUM_ENG  one-hot valid, bit k targets engine k
eng_tready  in  NUM_ENG  per-engine ready
eng_done  in  NUM_ENG  single-cycle completion pulse per engine
eng_busy  out  NUM_ENG  engine holds an issued, uncompleted config
err_valid  out  1  one-cycle pulse: config dropped, bad opcode
err_opcode  out  5  opcode of the dropped word, valid with err_valid
err_count  out  8  saturating count of dropped words
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset_n low at a clock edge):
  - FIFO flushed, so fifo_level=0 and cfg_in_tready=0 during reset.
  - eng_tvalid=0, eng_tdata=0, eng_busy=0, err_valid=0, err_opcode=0, err_count=0, state=IDLE.
  - Mid-issue reset drops the in-flight word with no handshake completed.
- cfg_in_tready = !full and out of reset, driven from registered FIFO state.
  - Push occurs when cfg_in_tvalid && cfg_in_tready.
  - A push and a pop in the same cycle are both honoured; the level is unchanged.
- FSM states:
  - IDLE: if FIFO is non-empty, decode opc = head[4:0].
    - opc >= NUM_ENG: pop head. Next cycle err_valid=1, err_opcode=opc, err_count += 1 (saturates at 255). Stay IDLE.
    - opc < NUM_ENG and !eng_busy[opc]: register eng_tdata = head[117:5] and eng_tvalid = 1<<opc, then go to ISSUE.
    - opc < NUM_ENG and eng_busy[opc]: hold in IDLE. In-order delivery, no bypass (head-of-line blocking is intentional).
  - ISSUE: hold eng_tdata and eng_tvalid stable until eng_tready[opc]=1.
    - On that handshake edge: pop FIFO, set eng_busy[opc], clear eng_tvalid, return to IDLE.
- eng_busy[k] clears on eng_done[k].
  - eng_done for a non-busy engine is ignored.
  - done[k] and issue to k cannot coincide, because issue requires !busy[k].
  - done[k] during ISSUE to engine j≠k is independent.
- Latency: with an empty FIFO and an idle target, input handshake in cycle t gives eng_tvalid high in cycle t+2.
  - Back-to-back issue rate is 1 word per 2 cycles (ISSUE→IDLE→ISSUE).
- eng_tready bits of non-selected engines are ignored.

Test Plan:
- Config opc=0, sub-op=5'h3, src addr=11'h12, engine 0 idle and ready → eng_tvalid=4'b0001 at t+2, eng_tdata=cfg[117:5], eng_busy[0]=1; after eng_done[0] pulse, eng_busy[0]=0.
- Two words with opc=1 back-to-back, eng_done[1] withheld → second word stays at FIFO head with eng_tvalid=0 and fifo_level=1; eng_done[1] pulse → second issue follows 2 cycles later.
- Word with opc=7 (NUM_ENG=4) → no eng_tvalid, err_valid pulse with err_opcode=7, err_count=1; a following opc=2 word issues normally.
- Hold all eng_tready=0 and push 5 words → cfg_in_tready drops after 4 (fifo_level=4) and eng_tvalid/eng_tdata stay stable; raise eng_tready → in-order drain and tready reasserts.
- Assert reset_n=0 while in ISSUE with fifo_level=3 → next cycle eng_tvalid=0, fifo_level=0, eng_busy=0, err_count=0.
- 260 bad-opcode words → err_count saturates at 255.
